// File: rtl/ov_fifo_reader.sv
// -----------------------------------------------------------------------------
// ov_fifo_reader
//
// Read engine for the AL422B frame FIFO sitting behind the OV7670 camera.
// For every frame announced by the write-side controller it runs the FIFO
// read-pointer reset sequence, then clocks bytes out of the FIFO one at a
// time.  Each byte is offered to the downstream sink on a valid/ready
// handshake.  rclk is held low while a byte waits, so the FIFO output stays
// stable no matter how long the sink stalls.
//
// Parameters
//   H_PIXELS        pixels per line
//   V_LINES         lines per frame
//   BYTES_PER_PIXEL bytes per pixel (1..4)
//   RCLK_HALF       clk_25MHz cycles per rclk half-period (>= 1)
//
// Ports
//   clk_25MHz       in   system clock
//   rst_n           in   asynchronous active-low reset
//   initialized     in   camera configured; while low everything freezes
//   new_frame       in   FIFO holds a complete frame (sampled in IDLE only)
//   abort           in   single-cycle request to drop the current frame
//   fifo_data[7:0]  in   FIFO DO bus
//   rclk            out  FIFO read clock
//   rrst            out  FIFO read-pointer reset, active-low
//   frame_read      out  high when idle, low while a frame is being read
//   out_valid       out  out_data holds a byte for the sink
//   out_ready       in   sink accepts the byte
//   out_data[7:0]   out  byte to the sink
//   out_last_line   out  qualifies the last byte of each line
//   out_last_frame  out  qualifies the last byte of the frame
//   frame_cnt[7:0]  out  completed frames, wraps 255 -> 0
//
// Build option
//   OV_FIFO_RD_CRLF_EN  when defined, a 0x0D 0x0A trailer follows the last
//                       pixel byte; out_last_frame then marks the 0x0A.
// -----------------------------------------------------------------------------
module ov_fifo_reader #(
  parameter int H_PIXELS        = 320,
  parameter int V_LINES         = 240,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int RCLK_HALF       = 1
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       initialized,
  input  logic       new_frame,
  input  logic       abort,
  input  logic [7:0] fifo_data,
  output logic       rclk,
  output logic       rrst,
  output logic       frame_read,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last_line,
  output logic       out_last_frame,
  output logic [7:0] frame_cnt
);

  localparam int BPL = H_PIXELS * BYTES_PER_PIXEL;
  localparam int BCW = $clog2(BPL + 1);
  localparam int LCW = $clog2(V_LINES + 1);
  localparam int HCW = $clog2(RCLK_HALF + 1);

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPL - 1);
  localparam logic [LCW-1:0] LINE_LAST = LCW'(V_LINES - 1);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(RCLK_HALF - 1);

  // Reset sequence has six steps (0..5); step 5 leaves rclk high.
  localparam logic [2:0] STEP_LAST = 3'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HI    = 3'd4;
`ifdef OV_FIFO_RD_CRLF_EN
  localparam logic [2:0] S_TRL   = 3'd5;
  localparam logic [2:0] S_TWAIT = 3'd6;
`endif
  localparam logic [2:0] S_DONE  = 3'd7;

  // State and counters
  logic [2:0]     r_state;
  logic [2:0]     r_step;
  logic [HCW-1:0] r_half_cnt;
  logic [BCW-1:0] r_byte_cnt;
  logic [LCW-1:0] r_line_cnt;
`ifdef OV_FIFO_RD_CRLF_EN
  logic           r_trl_idx;
`endif

  // Registered outputs
  logic           r_rclk;
  logic           r_rrst;
  logic           r_frame_read;
  logic           r_out_valid;
  logic [7:0]     r_out_data;
  logic           r_last_line;
  logic           r_last_frame;
  logic [7:0]     r_frame_cnt;

  // Next-state values
  logic [2:0]     w_state_nxt;
  logic [2:0]     w_step_nxt;
  logic [HCW-1:0] w_half_nxt;
  logic [BCW-1:0] w_byte_nxt;
  logic [LCW-1:0] w_line_nxt;
`ifdef OV_FIFO_RD_CRLF_EN
  logic           w_trl_nxt;
`endif
  logic           w_rclk_nxt;
  logic           w_rrst_nxt;
  logic           w_frame_read_nxt;
  logic           w_valid_nxt;
  logic [7:0]     w_data_nxt;
  logic           w_last_line_nxt;
  logic           w_last_frame_nxt;
  logic [7:0]     w_frame_cnt_nxt;

  // Decoded conditions
  logic w_half_last;
  logic w_byte_last;
  logic w_line_last;
  logic w_xfer;

  assign w_half_last = (r_half_cnt == HALF_LAST);
  assign w_byte_last = (r_byte_cnt == BYTE_LAST);
  assign w_line_last = (r_line_cnt == LINE_LAST);
  assign w_xfer      = r_out_valid & out_ready;

  // Next-state logic for the read sequencer and all registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_step_nxt       = r_step;
    w_half_nxt       = r_half_cnt;
    w_byte_nxt       = r_byte_cnt;
    w_line_nxt       = r_line_cnt;
`ifdef OV_FIFO_RD_CRLF_EN
    w_trl_nxt        = r_trl_idx;
`endif
    w_rclk_nxt       = r_rclk;
    w_rrst_nxt       = r_rrst;
    w_frame_read_nxt = r_frame_read;
    w_valid_nxt      = r_out_valid;
    w_data_nxt       = r_out_data;
    w_last_line_nxt  = r_last_line;
    w_last_frame_nxt = r_last_frame;
    w_frame_cnt_nxt  = r_frame_cnt;

    if (!initialized) begin
      // Camera not configured: everything holds its current value.
      w_state_nxt = r_state;
    end else if (abort && (r_state != S_IDLE)) begin
      // Abort wins over everything, including a simultaneous transfer.
      w_state_nxt      = S_IDLE;
      w_valid_nxt      = 1'b0;
      w_rrst_nxt       = 1'b1;
      w_rclk_nxt       = 1'b1;
      w_frame_read_nxt = 1'b1;
      w_last_line_nxt  = 1'b0;
      w_last_frame_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (new_frame) begin
            // First reset step (rrst low) is applied on the way into RST.
            w_state_nxt      = S_RST;
            w_frame_read_nxt = 1'b0;
            w_step_nxt       = 3'd0;
            w_half_nxt       = {HCW{1'b0}};
            w_byte_nxt       = {BCW{1'b0}};
            w_line_nxt       = {LCW{1'b0}};
            w_rrst_nxt       = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end

        S_RST: begin
          if (w_half_last) begin
            w_half_nxt = {HCW{1'b0}};
            if (r_step == STEP_LAST) begin
              w_state_nxt = S_LO;
              w_rclk_nxt  = 1'b0;
            end else begin
              w_step_nxt = r_step + 3'd1;
              // Output change that belongs to the step being entered.
              case (r_step)
                3'd0:    w_rclk_nxt = 1'b0;
                3'd1:    w_rclk_nxt = 1'b1;  // rising edge with rrst low
                3'd2:    w_rclk_nxt = 1'b0;
                3'd3:    w_rrst_nxt = 1'b1;
                3'd4:    w_rclk_nxt = 1'b1;  // first read edge, loads byte 0
                default: w_rclk_nxt = r_rclk;
              endcase
            end
          end else begin
            w_half_nxt = r_half_cnt + HCW'(1);
          end
        end

        S_LO: begin
          if (w_half_last) begin
            w_half_nxt      = {HCW{1'b0}};
            w_state_nxt     = S_WAIT;
            w_data_nxt      = fifo_data;
            w_valid_nxt     = 1'b1;
            w_last_line_nxt = w_byte_last;
`ifdef OV_FIFO_RD_CRLF_EN
            // With the trailer enabled the frame ends on 0x0A, not here.
            w_last_frame_nxt = 1'b0;
`else
            w_last_frame_nxt = w_byte_last & w_line_last;
`endif
          end else begin
            w_half_nxt = r_half_cnt + HCW'(1);
          end
        end

        S_WAIT: begin
          if (w_xfer) begin
            w_valid_nxt      = 1'b0;
            w_rclk_nxt       = 1'b1;
            w_last_line_nxt  = 1'b0;
            w_last_frame_nxt = 1'b0;
            w_half_nxt       = {HCW{1'b0}};
            if (w_byte_last) begin
              w_byte_nxt = {BCW{1'b0}};
              if (w_line_last) begin
`ifdef OV_FIFO_RD_CRLF_EN
                w_state_nxt = S_TRL;
                w_trl_nxt   = 1'b0;
`else
                w_state_nxt = S_DONE;
`endif
              end else begin
                w_line_nxt  = r_line_cnt + LCW'(1);
                w_state_nxt = S_HI;
              end
            end else begin
              w_byte_nxt  = r_byte_cnt + BCW'(1);
              w_state_nxt = S_HI;
            end
          end else begin
            w_state_nxt = S_WAIT;
          end
        end

        S_HI: begin
          if (w_half_last) begin
            w_half_nxt  = {HCW{1'b0}};
            w_rclk_nxt  = 1'b0;
            w_state_nxt = S_LO;
          end else begin
            w_half_nxt = r_half_cnt + HCW'(1);
          end
        end

`ifdef OV_FIFO_RD_CRLF_EN
        S_TRL: begin
          // Trailer bytes come from constants; rclk stays high throughout.
          w_data_nxt       = 8'h0D;
          w_valid_nxt      = 1'b1;
          w_last_line_nxt  = 1'b0;
          w_last_frame_nxt = 1'b0;
          w_trl_nxt        = 1'b0;
          w_state_nxt      = S_TWAIT;
        end

        S_TWAIT: begin
          if (w_xfer) begin
            if (r_trl_idx == 1'b0) begin
              w_data_nxt       = 8'h0A;
              w_last_frame_nxt = 1'b1;
              w_trl_nxt        = 1'b1;
            end else begin
              w_valid_nxt      = 1'b0;
              w_last_frame_nxt = 1'b0;
              w_state_nxt      = S_DONE;
            end
          end else begin
            w_state_nxt = S_TWAIT;
          end
        end
`endif

        S_DONE: begin
          w_frame_read_nxt = 1'b1;
          w_frame_cnt_nxt  = r_frame_cnt + 8'd1;
          w_state_nxt      = S_IDLE;
        end

        default: begin
          // Unreachable encoding: return to a safe idle condition.
          w_state_nxt      = S_IDLE;
          w_valid_nxt      = 1'b0;
          w_rclk_nxt       = 1'b1;
          w_rrst_nxt       = 1'b1;
          w_frame_read_nxt = 1'b1;
          w_last_line_nxt  = 1'b0;
          w_last_frame_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_step       <= 3'd0;
      r_half_cnt   <= {HCW{1'b0}};
      r_byte_cnt   <= {BCW{1'b0}};
      r_line_cnt   <= {LCW{1'b0}};
`ifdef OV_FIFO_RD_CRLF_EN
      r_trl_idx    <= 1'b0;
`endif
      r_rclk       <= 1'b1;
      r_rrst       <= 1'b1;
      r_frame_read <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_last_line  <= 1'b0;
      r_last_frame <= 1'b0;
      r_frame_cnt  <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_step       <= w_step_nxt;
      r_half_cnt   <= w_half_nxt;
      r_byte_cnt   <= w_byte_nxt;
      r_line_cnt   <= w_line_nxt;
`ifdef OV_FIFO_RD_CRLF_EN
      r_trl_idx    <= w_trl_nxt;
`endif
      r_rclk       <= w_rclk_nxt;
      r_rrst       <= w_rrst_nxt;
      r_frame_read <= w_frame_read_nxt;
      r_out_valid  <= w_valid_nxt;
      r_out_data   <= w_data_nxt;
      r_last_line  <= w_last_line_nxt;
      r_last_frame <= w_last_frame_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign rclk           = r_rclk;
  assign rrst           = r_rrst;
  assign frame_read     = r_frame_read;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last_line  = r_last_line;
  assign out_last_frame = r_last_frame;
  assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_ov_fifo_reader.sv
// -----------------------------------------------------------------------------
// Bench for ov_fifo_reader with a 4x2 frame, 2 bytes per pixel, RCLK_HALF=1.
// An AL422B read-side model feeds incrementing bytes; the expected byte stream
// is a queue built from frame geometry and checked at every handshake.
// -----------------------------------------------------------------------------
module tb_ov_fifo_reader;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int BPP  = 2;
  localparam int RH   = 1;
  localparam int BPL  = H * BPP;
  localparam int NPIX = H * V * BPP;
`ifdef OV_FIFO_RD_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif
  localparam int NB        = NPIX + (CRLF ? 2 : 0);
  // 1 + 7 + 15*3 + 1 + 1 = 55; trailer adds three cycles.
  localparam int FRAME_CYC = CRLF ? 58 : 55;

  logic       clk_25MHz;
  logic       rst_n;
  logic       initialized;
  logic       new_frame;
  logic       abort;
  logic [7:0] fifo_data = 8'hEE;
  logic       rclk;
  logic       rrst;
  logic       frame_read;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last_line;
  logic       out_last_frame;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  ov_fifo_reader #(
    .H_PIXELS(H), .V_LINES(V), .BYTES_PER_PIXEL(BPP), .RCLK_HALF(RH)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .initialized(initialized),
    .new_frame(new_frame), .abort(abort), .fifo_data(fifo_data),
    .rclk(rclk), .rrst(rrst), .frame_read(frame_read),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_line(out_last_line), .out_last_frame(out_last_frame),
    .frame_cnt(frame_cnt)
  );

  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // FIFO read side: rising rclk with rrst low rewinds, otherwise outputs next byte.
  int fifo_ptr   = 0;
  int rclk_rises = 0;
  int rrst_falls = 0;
  always @(posedge rclk) begin
    rclk_rises = rclk_rises + 1;
    if (!rrst) fifo_ptr = 0;
    else begin
      fifo_data <= 8'(fifo_ptr);
      fifo_ptr = fifo_ptr + 1;
    end
  end
  always @(negedge rrst) rrst_falls = rrst_falls + 1;

  // Expected stream: {data, last_line, last_frame}
  logic [9:0] exp_q[$];
  int         xfer_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rclk = 1'b1;

  task automatic load_frame();
    exp_q.delete();
    for (int i = 0; i < NPIX; i++)
      exp_q.push_back({8'(i), ((i % BPL) == BPL - 1), ((i == NPIX - 1) && !CRLF)});
    if (CRLF) begin
      exp_q.push_back({8'h0D, 1'b0, 1'b0});
      exp_q.push_back({8'h0A, 1'b0, 1'b1});
    end
  endtask

  // Compare process: handshake scoreboard plus hold-stability during stalls.
  always @(negedge clk_25MHz) begin
    logic [9:0] e;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_rclk", rclk, prev_rclk);
      end
      if (out_valid && out_ready) begin
        xfer_cnt = xfer_cnt + 1;
        if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("data", out_data, e[9:2]);
          check("last_line", out_last_line, e[1]);
          check("last_frame", out_last_frame, e[0]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_rclk  = rclk;
    end
  end

  logic rand_ready = 1'b0;

  task automatic step();
    @(posedge clk_25MHz);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (frame_read == 1'b0 && n < bound) begin
      step();
      n++;
    end
    check("frame_end_timeout", frame_read, 1'b1);
  endtask

  initial begin
    int k, vcount, x0, x1, r0, f0, n;
    rst_n = 1'b0; initialized = 1'b0; new_frame = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk_25MHz);
    #1;
    check("rst_rclk", rclk, 1'b1);
    check("rst_rrst", rrst, 1'b1);
    check("rst_frame_read", frame_read, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_flags", {out_last_line, out_last_frame}, 2'b00);
    check("rst_frame_cnt", frame_cnt, 8'h00);
    rst_n = 1'b1; initialized = 1'b1;
    step();

    // Frame A: full-rate, timing pinned to literals, busy new_frame ignored.
    load_frame(); f0 = rrst_falls; x0 = xfer_cnt;
    new_frame = 1'b1; step(); new_frame = 1'b0; k = 1;
    check("frame_read_low", frame_read, 1'b0);
    vcount = 0;
    while (frame_read == 1'b0 && k < 300) begin
      if (out_valid) begin
        if (vcount < NPIX) check("byte_spacing", k, 8 + 3 * vcount);
        vcount++;
      end
      if (k == 8)  check("first_byte", out_data, 8'h00);
      if (k == 29) check("line0_last", out_last_line, 1'b1);
      if (k == 53) begin
        check("last_pix_data", out_data, 8'h0F);
        check("last_pix_frame", out_last_frame, CRLF ? 1'b0 : 1'b1);
      end
      new_frame = (k == 20);
      step(); k++;
    end
    new_frame = 1'b0;
    check("frame_cycles", k, FRAME_CYC);
    check("valid_count", vcount, NB);
    check("frame_cnt_a", frame_cnt, 8'd1);
    check("rrst_pulses_a", rrst_falls - f0, 1);
    check("queue_empty_a", exp_q.size(), 0);
    check("xfers_a", xfer_cnt - x0, NB);

    // Frame B: random backpressure.
    load_frame(); x0 = xfer_cnt; rand_ready = 1'b1;
    new_frame = 1'b1; step(); new_frame = 1'b0;
    wait_idle(3000);
    rand_ready = 1'b0; out_ready = 1'b1;
    check("frame_cnt_b", frame_cnt, 8'd2);
    check("queue_empty_b", exp_q.size(), 0);
    check("xfers_b", xfer_cnt - x0, NB);

    // Frame C: abort after byte 5.
    load_frame(); x0 = xfer_cnt;
    new_frame = 1'b1; step(); new_frame = 1'b0;
    n = 0;
    while ((xfer_cnt - x0) < 6 && n < 500) begin step(); n++; end
    check("abort_reach", xfer_cnt - x0, 6);
    abort = 1'b1; step(); abort = 1'b0;
    exp_q.delete();
    check("abort_valid", out_valid, 1'b0);
    check("abort_frame_read", frame_read, 1'b1);
    check("abort_rrst_rclk", {rrst, rclk}, 2'b11);
    check("abort_frame_cnt", frame_cnt, 8'd2);
    step();
    check("abort_stays_idle", {frame_read, out_valid}, 2'b10);

    // Frame D: restart from byte 0, with a 10-cycle initialized drop.
    load_frame(); x0 = xfer_cnt; f0 = rrst_falls;
    new_frame = 1'b1; step(); new_frame = 1'b0;
    n = 0;
    while (!((xfer_cnt - x0) >= 3 && out_valid == 1'b0) && n < 500) begin step(); n++; end
    initialized = 1'b0; r0 = rclk_rises; x1 = xfer_cnt;
    repeat (10) step();
    check("freeze_rclk", rclk_rises - r0, 0);
    check("freeze_xfer", xfer_cnt - x1, 0);
    check("freeze_valid", out_valid, 1'b0);
    initialized = 1'b1;
    wait_idle(500);
    check("frame_cnt_d", frame_cnt, 8'd3);
    check("queue_empty_d", exp_q.size(), 0);
    check("rrst_pulses_d", rrst_falls - f0, 1);
    check("xfers_d", xfer_cnt - x0, NB);

    // Frame E: asynchronous reset in mid-frame.
    load_frame();
    new_frame = 1'b1; step(); new_frame = 1'b0;
    repeat (20) step();
    #5 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_rclk", rclk, 1'b1);
    check("mid_rst_rrst", rrst, 1'b1);
    check("mid_rst_frame_read", frame_read, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_flags", {out_last_line, out_last_frame}, 2'b00);
    check("mid_rst_frame_cnt", frame_cnt, 8'h00);
    step(); rst_n = 1'b1; step();

    // Frame F: clean frame after reset.
    load_frame(); x0 = xfer_cnt; f0 = rrst_falls;
    new_frame = 1'b1; step(); new_frame = 1'b0;
    wait_idle(500);
    check("frame_cnt_f", frame_cnt, 8'd1);
    check("queue_empty_f", exp_q.size(), 0);
    check("rrst_pulses_f", rrst_falls - f0, 1);
    check("xfers_f", xfer_cnt - x0, NB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov_fifo_reader.md
# ov_fifo_reader

Parametrised read engine for the AL422B frame FIFO behind the OV7670 camera. It replaces the fixed 320×240 reader. Per frame it issues the FIFO read-reset sequence, drives `rclk`, and streams each byte through a valid/ready handshake instead of fixed pacing delays. It marks line and frame boundaries, supports abort, and keeps a frame counter. It sits between the FIFO write-side controller (`new_frame`/`frame_read`) and the UART/host byte sink.

## Interface
- `H_PIXELS`, 320, pixels per line
- `V_LINES`, 240, lines per frame
- `BYTES_PER_PIXEL`, 2, bytes per pixel (1..4)
- `RCLK_HALF`, 1, `clk_25MHz` cycles per `rclk` half-period (≥1)
- `clk_25MHz`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `initialized`  in  1  camera configured; while low, FSM and counters freeze (outputs hold)
- `new_frame`  in  1  FIFO holds a complete frame; sampled only in IDLE
- `abort`  in  1  single-cycle request to drop the current frame
- `fifo_data`  in  8  FIFO DO bus
- `rclk`  out  1  FIFO read clock
- `rrst`  out  1  FIFO read-pointer reset, active-low
- `frame_read`  out  1  high = idle (frame consumed); low while reading
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  sink accepts byte
- `out_data`  out  8  byte
- `out_last_line`  out  1  qualifies last byte of each line
- `out_last_frame`  out  1  qualifies last byte of frame
- `frame_cnt`  out  8  completed frames, wraps 255→0

## Operation
- Reset values: `rclk`=1, `rrst`=1, `frame_read`=1, `out_valid`=0, `out_data`=0, `out_last_line`=0, `out_last_frame`=0, `frame_cnt`=0, state IDLE. Reset mid-frame aborts immediately. The next frame re-runs the `rrst` sequence.
- All transitions below are gated by `initialized`=1.
- IDLE: when `new_frame`=1, set `frame_read`←0, clear counters, go to RST.
- RST sequence, one state per `RCLK_HALF` cycles:
  - `rrst`←0
  - `rclk`←0
  - `rclk`←1
  - `rclk`←0
  - `rrst`←1
  - `rclk`←1
  - Then go to LO.
- LO: `rclk`=0 for `RCLK_HALF` cycles. On the last cycle, capture `fifo_data` into `out_data`, set `out_valid`←1 and flags, and go to WAIT.
- WAIT: hold `out_data` and flags stable until `out_valid`&`out_ready`. On transfer:
  - `out_valid`←0, `rclk`←1.
  - Advance the byte counter (`0..H_PIXELS*BYTES_PER_PIXEL-1`) and line counter (`0..V_LINES-1`).
  - Go to HI, or to TRAILER/DONE after the final byte.
- HI: `rclk`=1 for `RCLK_HALF` cycles, then LO.
- DONE: `frame_read`←1, `frame_cnt`+1, go to IDLE.
- `out_last_line` is asserted with byte index `H_PIXELS*BYTES_PER_PIXEL-1` of every line.
- `out_last_frame` is asserted on the final frame byte, or on the trailer `0x0A` when the trailer is enabled.
- Counter widths: `$clog2` of (count+1). There is no arithmetic overflow within a frame.
- `abort` (any non-IDLE state): next cycle `out_valid`←0, `rrst`←1, `rclk`←1, `frame_read`←1, state IDLE. No trailer is sent, and `frame_cnt` is unchanged. `abort` in IDLE is ignored.
- `new_frame` while busy is ignored.
- `abort` together with a WAIT transfer: the byte counts as delivered, and the abort wins.

## Timing
- Latency from `new_frame` (IDLE) to `frame_read` low: 1 cycle.
- Latency from `new_frame` to first `out_valid`: 1 + 6·`RCLK_HALF` + `RCLK_HALF` cycles.
- Byte period with `out_ready` held high: 2·`RCLK_HALF`+1 cycles (3 cycles, 8.33 MB/s at default).
- `out_ready` low stretches the WAIT phase. `rclk` stays low, so the FIFO output is stable.
- `out_valid` never deasserts without a transfer or an abort.
- Frame cycles with `out_ready`=1: 1 + 7·`RCLK_HALF` + (N−1)(2·`RCLK_HALF`+1) + 1 + 1 (DONE), where N = `H_PIXELS`·`V_LINES`·`BYTES_PER_PIXEL`, plus trailer.

## Configuration
- `OV_FIFO_RD_CRLF_EN` defined: after the last pixel byte, emit `0x0D` then `0x0A` through the same handshake, each occupying one WAIT phase with no `rclk` activity. `out_last_frame` qualifies `0x0A` only, and `out_last_line` is 0 on both trailer bytes.
- `OV_FIFO_RD_CRLF_EN` undefined: no trailer; DONE follows the last pixel transfer directly.

## Test plan
- H=4, V=2, BPP=2, `RCLK_HALF`=1, `out_ready`=1, FIFO model returning an incrementing byte per `rclk` rise after reset → 16 bytes 0x00..0x0F. `out_last_line` on bytes 7 and 15, `out_last_frame` on 15, 3-cycle spacing, `frame_cnt`=1, `frame_read` high.
- Same with `OV_FIFO_RD_CRLF_EN` → 18 bytes ending 0x0D, 0x0A. `out_last_frame` on 0x0A only.
- Random `out_ready` backpressure (50%) → identical byte sequence; `out_data` and `rclk` stable while `out_valid`&!`out_ready`.
- `abort` after byte 5 → `out_valid` low next cycle, `frame_read`=1, `frame_cnt` unchanged. A following `new_frame` re-runs `rrst` and delivers 0x00 first.
- `initialized` dropped for 10 cycles mid-frame → no `rclk` edges or transfers during that time; sequence resumes intact.
- `rst_n` asserted mid-frame → all outputs return to reset values asynchronously; a second `new_frame` while busy produces no extra `rrst` pulse.
